// File: rtl/alarm_display_ctrl_if.sv
// Signal bundle between the time/alarm logic and the display scan controller.
// The master drives alarm, snooze and digits; the controller returns the pin-level outputs.
interface alarm_display_ctrl_if;
    logic        alarm;
    logic        snooze;
    logic [15:0] digits;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  mode;

    modport master (output alarm, snooze, digits, input  seg, an, mode);
    modport slave  (input  alarm, snooze, digits, output seg, an, mode);
endinterface

// File: rtl/alarm_display_ctrl.sv
// Four-digit seven-segment scan controller with alarm blink and snooze sequencing.
// Outputs are registered one cycle behind the internal state, scan index and digits.
module alarm_display_ctrl #(
    parameter int SCAN_DIV   = 4,
    parameter int BLINK_LEN  = 16,
    parameter int SNOOZE_LEN = 64
) (
    input logic                 clk,
    input logic                 reset,
    alarm_display_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        BLINK_ON  = 2'd1,
        BLINK_OFF = 2'd2,
        SNOOZE    = 2'd3
    } state_t;

    localparam int PH_MAX = (BLINK_LEN > SNOOZE_LEN) ? BLINK_LEN : SNOOZE_LEN;
    localparam int PH_W   = $clog2(PH_MAX);
    localparam int SC_W   = $clog2(SCAN_DIV);

    localparam logic [PH_W-1:0] BLINK_END  = PH_W'(BLINK_LEN - 1);
    localparam logic [PH_W-1:0] SNOOZE_END = PH_W'(SNOOZE_LEN - 1);
    localparam logic [SC_W-1:0] SCAN_END   = SC_W'(SCAN_DIV - 1);

    state_t          state_q, state_d;
    logic [PH_W-1:0] ph_cnt;
    logic [SC_W-1:0] scan_cnt;
    logic [1:0]      idx;
    logic [3:0]      digit_sel;
    logic            disp_active;
    logic [6:0]      seg_d, seg_q;
    logic [3:0]      an_d, an_q;
    logic [1:0]      mode_q;

    // Segment order is {A,B,C,D,E,F,G}; codes 10-15 blank the digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1111110;
            4'd1:    seg_decode = 7'b0110000;
            4'd2:    seg_decode = 7'b1101101;
            4'd3:    seg_decode = 7'b1111001;
            4'd4:    seg_decode = 7'b0110011;
            4'd5:    seg_decode = 7'b1011011;
            4'd6:    seg_decode = 7'b1011111;
            4'd7:    seg_decode = 7'b1110000;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1111011;
            default: seg_decode = 7'b0000000;
        endcase
    endfunction

    // NOTE: next-state defaults to the current state before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL: begin
                if (bus.alarm) state_d = BLINK_ON;
            end
            BLINK_ON: begin
                if (!bus.alarm)              state_d = NORMAL;
                else if (bus.snooze)         state_d = SNOOZE;
                else if (ph_cnt == BLINK_END) state_d = BLINK_OFF;
            end
            BLINK_OFF: begin
                if (!bus.alarm)              state_d = NORMAL;
                else if (bus.snooze)         state_d = SNOOZE;
                else if (ph_cnt == BLINK_END) state_d = BLINK_ON;
            end
            SNOOZE: begin
                if (!bus.alarm)               state_d = NORMAL;
                else if (ph_cnt == SNOOZE_END) state_d = BLINK_ON;
            end
            default: state_d = NORMAL;
        endcase
    end

    always_comb begin
        digit_sel   = bus.digits[{idx, 2'b00} +: 4];
        disp_active = (state_q != BLINK_OFF);
        seg_d       = '0;
        an_d        = '0;
        if (disp_active) begin
            seg_d = seg_decode(digit_sel);
            an_d  = 4'b0001 << idx;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= NORMAL;
            ph_cnt   <= '0;
            scan_cnt <= '0;
            idx      <= '0;
            seg_q    <= '0;
            an_q     <= '0;
            mode_q   <= '0;
        end else begin
            state_q <= state_d;
            // Phase counter restarts on every state change and idles at zero in NORMAL.
            if (state_d != state_q || state_q == NORMAL) ph_cnt <= '0;
            else                                         ph_cnt <= ph_cnt + 1'b1;
            if (scan_cnt == SCAN_END) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            seg_q  <= seg_d;
            an_q   <= an_d;
            mode_q <= state_q;
        end
    end

    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.mode = mode_q;

endmodule

// File: tb/tb_alarm_display_ctrl.sv
// Self-checking bench for alarm_display_ctrl: table-driven scan vectors, directed
// blink/snooze/reset sequences and a randomized run against a behavioural model.
module tb_alarm_display_ctrl;

    localparam int SCAN_DIV   = 4;
    localparam int BLINK_LEN  = 16;
    localparam int SNOOZE_LEN = 64;

    localparam int M_NORMAL = 0, M_BLINK_ON = 1, M_BLINK_OFF = 2, M_SNOOZE = 3;

    logic clk;
    logic reset;
    alarm_display_ctrl_if bus ();

    alarm_display_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_LEN (BLINK_LEN),
        .SNOOZE_LEN(SNOOZE_LEN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: elapsed edges since reset, current mode and cycles spent in it.
    int m_t, m_mode, m_dwell;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  an;
        logic [6:0]  seg;
    } slot_vec_t;

    slot_vec_t vecs[9];

    function automatic logic [6:0] ref_seg(input int d);
        // Bits listed A..G.
        case (d)
            0: ref_seg = 7'b1111110;  // ABCDEF
            1: ref_seg = 7'b0110000;  // BC
            2: ref_seg = 7'b1101101;  // ABDEG
            3: ref_seg = 7'b1111001;  // ABCDG
            4: ref_seg = 7'b0110011;  // BCFG
            5: ref_seg = 7'b1011011;  // ACDFG
            6: ref_seg = 7'b1011111;  // ACDEFG
            7: ref_seg = 7'b1110000;  // ABC
            8: ref_seg = 7'b1111111;
            9: ref_seg = 7'b1111011;  // ABCDFG
            default: ref_seg = 7'b0000000;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t     = 0;
        m_mode  = M_NORMAL;
        m_dwell = 0;
    endtask

    // One clock edge: predict outputs from the model, advance the model, compare after the edge.
    task automatic step();
        int          slot;
        int          dig;
        int          nxt;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic [1:0]  e_mode;
        slot   = (m_t / SCAN_DIV) % 4;
        dig    = int'((bus.digits >> (4 * slot)) & 16'hF);
        e_mode = 2'(m_mode);
        if (m_mode == M_BLINK_OFF) begin
            e_an  = 4'b0000;
            e_seg = 7'b0000000;
        end else begin
            e_an  = 4'(1 << slot);
            e_seg = ref_seg(dig);
        end
        nxt = m_mode;
        case (m_mode)
            M_NORMAL:  if (bus.alarm) nxt = M_BLINK_ON;
            M_SNOOZE:  if (!bus.alarm) nxt = M_NORMAL;
                       else if (m_dwell == SNOOZE_LEN - 1) nxt = M_BLINK_ON;
            default: begin
                if (!bus.alarm) nxt = M_NORMAL;
                else if (bus.snooze) nxt = M_SNOOZE;
                else if (m_dwell == BLINK_LEN - 1)
                    nxt = (m_mode == M_BLINK_ON) ? M_BLINK_OFF : M_BLINK_ON;
            end
        endcase
        m_dwell = (nxt != m_mode) ? 0 : m_dwell + 1;
        m_mode  = nxt;
        m_t++;
        @(posedge clk);
        #1;
        check("model_an",   16'(bus.an),   16'(e_an));
        check("model_seg",  16'(bus.seg),  16'(e_seg));
        check("model_mode", 16'(bus.mode), 16'(e_mode));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h1234, 4'b0001, 7'b0110011};
        vecs[1] = '{16'h1234, 4'b0010, 7'b1111001};
        vecs[2] = '{16'h1234, 4'b0100, 7'b1101101};
        vecs[3] = '{16'h1234, 4'b1000, 7'b0110000};
        vecs[4] = '{16'h1234, 4'b0001, 7'b0110011};
        vecs[5] = '{16'h00F0, 4'b0010, 7'b0000000};
        vecs[6] = '{16'h00F0, 4'b0100, 7'b1111110};
        vecs[7] = '{16'h00F0, 4'b1000, 7'b1111110};
        vecs[8] = '{16'h00F0, 4'b0001, 7'b1111110};

        clk        = 1'b0;
        reset      = 1'b0;
        bus.alarm  = 1'b0;
        bus.snooze = 1'b0;
        bus.digits = 16'h1234;
        #2 reset = 1'b1;
        #1;
        check("reset_an",   16'(bus.an),   16'h0);
        check("reset_seg",  16'(bus.seg),  16'h0);
        check("reset_mode", 16'(bus.mode), 16'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Scan order and blank code, one table row per scan slot.
        for (int v = 0; v < 9; v++) begin
            bus.digits = vecs[v].digits;
            for (int c = 0; c < SCAN_DIV; c++) begin
                step();
                check("scan_an",   16'(bus.an),   16'(vecs[v].an));
                check("scan_seg",  16'(bus.seg),  16'(vecs[v].seg));
                check("scan_mode", 16'(bus.mode), 16'h0);
            end
        end

        // Blink: 16 cycles displayed, 16 blanked, then back on.
        bus.digits = 16'h1234;
        bus.alarm  = 1'b1;
        step();
        check("blink_entry_mode", 16'(bus.mode), 16'd0);
        for (int i = 0; i < BLINK_LEN; i++) begin
            step();
            check("blink_on_mode", 16'(bus.mode), 16'd1);
            check("blink_on_lit",  16'(bus.an != 4'b0000), 16'd1);
        end
        for (int i = 0; i < BLINK_LEN; i++) begin
            step();
            check("blink_off_mode", 16'(bus.mode), 16'd2);
            check("blink_off_an",   16'(bus.an),   16'h0);
            check("blink_off_seg",  16'(bus.seg),  16'h0);
        end
        step();
        check("blink_reon_mode", 16'(bus.mode), 16'd1);

        // Snooze from BLINK_OFF; second pulse mid-snooze must not extend it.
        for (int i = 0; i < BLINK_LEN; i++) step();
        check("pre_snooze_mode", 16'(bus.mode), 16'd2);
        bus.snooze = 1'b1;
        step();
        bus.snooze = 1'b0;
        step();
        check("snooze_mode", 16'(bus.mode), 16'd3);
        check("snooze_lit",  16'(bus.an != 4'b0000), 16'd1);
        for (int i = 2; i <= SNOOZE_LEN; i++) begin
            bus.snooze = (i == 30);
            step();
            check("snooze_hold_mode", 16'(bus.mode), 16'd3);
        end
        bus.snooze = 1'b0;
        step();
        check("snooze_expire_mode", 16'(bus.mode), 16'd1);
        bus.alarm = 1'b0;
        step();
        step();
        check("alarm_drop_mode", 16'(bus.mode), 16'd0);

        // Alarm falling together with snooze wins.
        bus.alarm = 1'b1;
        step();
        step();
        bus.alarm  = 1'b0;
        bus.snooze = 1'b1;
        step();
        bus.snooze = 1'b0;
        step();
        check("simul_drop_mode", 16'(bus.mode), 16'd0);

        // Snooze on the last blink-phase cycle beats the phase change.
        bus.alarm = 1'b1;
        step();
        for (int i = 0; i < BLINK_LEN - 1; i++) step();
        bus.snooze = 1'b1;
        step();
        bus.snooze = 1'b0;
        step();
        check("snooze_at_phase_end", 16'(bus.mode), 16'd3);

        // Snooze expiry coinciding with alarm drop returns to NORMAL.
        for (int i = 0; i < SNOOZE_LEN - 2; i++) step();
        bus.alarm = 1'b0;
        step();
        check("expiry_drop_last", 16'(bus.mode), 16'd3);
        step();
        check("expiry_drop_mode", 16'(bus.mode), 16'd0);

        // Randomized run against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) == 0) bus.alarm = ~bus.alarm;
            bus.snooze = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) bus.digits = 16'($urandom);
            step();
        end

        // Asynchronous reset in the middle of a snooze.
        bus.digits = 16'h1234;
        bus.snooze = 1'b0;
        bus.alarm  = 1'b0;
        step();
        bus.alarm = 1'b1;
        step();
        step();
        bus.snooze = 1'b1;
        step();
        bus.snooze = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("pre_reset_mode", 16'(bus.mode), 16'd3);
        #2 reset = 1'b1;
        #1;
        check("async_reset_an",   16'(bus.an),   16'h0);
        check("async_reset_seg",  16'(bus.seg),  16'h0);
        check("async_reset_mode", 16'(bus.mode), 16'h0);
        bus.alarm = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("held_reset_an", 16'(bus.an), 16'h0);
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < SCAN_DIV; c++) begin
            step();
            check("restart_an",  16'(bus.an),  16'b0001);
            check("restart_seg", 16'(bus.seg), 16'b0110011);
        end
        step();
        check("restart_next_an", 16'(bus.an), 16'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
